// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: 2-flop synchroniser, optional debounce, sticky edge-pending bits and irq.
// Define GPIO_DEBOUNCE_EN to build the per-bit debounce counters; otherwise stable_out follows sync2.
module gpio_in_cond #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  if (WIDTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("gpio_in_cond: WIDTH and DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] set_ev;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] pending_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_in;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt     [WIDTH];
  logic [CW-1:0] cnt_nxt [WIDTH];

  // Any return of sync2 to the accepted level restarts that bit's count from zero.
  always_comb begin
    stable_nxt = stable_out;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable_out[i]) begin
        if (cnt[i] == CNT_LAST) stable_nxt[i] = sync2[i];
        else                    cnt_nxt[i]    = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '{default: '0};
    else        cnt <= cnt_nxt;
  end
`else
  always_comb stable_nxt = sync2;
`endif

  // Edges are taken from the next-state level so pending sets on the same edge stable_out moves.
  always_comb begin
    set_ev      = (~stable_out & stable_nxt & rise_en) | (stable_out & ~stable_nxt & fall_en);
    clr_bits    = clr_valid ? clr_mask : '0;
    pending_nxt = (pending & ~clr_bits) | set_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_out <= '0;
      pending    <= '0;
    end else begin
      stable_out <= stable_nxt;
      pending    <= pending_nxt;
    end
  end

  assign irq = |(pending & irq_mask);

endmodule

// File: tb/tb_gpio_in_cond.sv
// Scoreboard bench for gpio_in_cond (WIDTH=8, DEBOUNCE_CYCLES=4); expectations adapt to GPIO_DEBOUNCE_EN.
module tb_gpio_in_cond;

`ifdef GPIO_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] pin;
  logic [7:0] rise_en;
  logic [7:0] fall_en;
  logic [7:0] irq_mask;
  logic       clr_valid;
  logic [7:0] clr_mask;
  logic [7:0] st_o;
  logic [7:0] pd_o;
  logic       irq_o;

  gpio_in_cond #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pin_in     (pin),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_mask   (irq_mask),
    .clr_valid  (clr_valid),
    .clr_mask   (clr_mask),
    .stable_out (st_o),
    .pending    (pd_o),
    .irq        (irq_o)
  );

  typedef struct {
    int         edge_n;
    logic [7:0] st;
    logic [7:0] pd;
    logic       iq;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [16:0] act, input logic [16:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual stable=%h pending=%h irq=%b required stable=%h pending=%h irq=%b",
               name, act[16:9], act[8:1], act[0], req[16:9], req[8:1], req[0]);
    end
  endtask

  task automatic push(input int e, input logic [7:0] st, input logic [7:0] pd, input logic iq);
    exp_t x;
    x.edge_n = e; x.st = st; x.pd = pd; x.iq = iq;
    sbq.push_back(x);
  endtask

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  // Pulse bit b high for L cycles on top of pin=0x01; passes the filter only when L >= D.
  task automatic pulse(input int b, input int L);
    int kk;
    logic [7:0] hi;
    hi = 8'h01 | (8'(1) << b);
    kk = cyc + 1;
    pin = hi;
    if (L >= D) begin
      push(kk + 1 + D, hi, 8'h01, 1'b1);
      push(kk + L + D, hi, 8'h01, 1'b1);
      push(kk + L + 1 + D, 8'h01, 8'h01, 1'b1);
    end else begin
      push(kk + 1 + D, 8'h01, 8'h01, 1'b1);
      push(kk + L + 1 + D, 8'h01, 8'h01, 1'b1);
    end
    wait_edge(kk + L - 1);
    pin = 8'h01;
    wait_edge(kk + L + 2 + D);
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    while (sbq.size() > 0 && sbq[0].edge_n <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.edge_n < cyc) begin
        total++;
        bad++;
        $display("FAIL edge%0d expectation missed at edge %0d", mon_e.edge_n, cyc);
      end else begin
        cmp($sformatf("edge%0d", mon_e.edge_n), {st_o, pd_o, irq_o}, {mon_e.st, mon_e.pd, mon_e.iq});
      end
    end
  end

  initial begin
    #100000;
    total++;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; pin = '0; rise_en = '0; fall_en = '0; irq_mask = '0;
    clr_valid = 1'b0; clr_mask = '0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(cyc + 1, 8'h00, 8'h00, 1'b0);

    // rising edge on bit 0
    @(negedge clk);
    pin = 8'h01; rise_en = 8'h01; irq_mask = 8'h01;
    k = cyc + 1;
    push(k + D, 8'h00, 8'h00, 1'b0);
    push(k + 1 + D, 8'h01, 8'h01, 1'b1);
    wait_edge(k + 2 + D);

    // glitches: 3 and 4 cycles on bit 1, 1 cycle on bit 5
    pulse(1, 3);
    pulse(1, 4);
    pulse(5, 1);

    clr_valid = 1'b1; clr_mask = 8'h01;
    push(cyc + 1, 8'h01, 8'h00, 1'b0);
    @(negedge clk);
    clr_valid = 1'b0; clr_mask = '0;

    // falling edge only on bit 2
    rise_en = 8'h00; fall_en = 8'h04; irq_mask = 8'h04; pin = 8'h05;
    k = cyc + 1;
    push(k + 1 + D, 8'h05, 8'h00, 1'b0);
    wait_edge(k + 2 + D);
    pin = 8'h01;
    k = cyc + 1;
    push(k + D, 8'h05, 8'h00, 1'b0);
    push(k + 1 + D, 8'h01, 8'h04, 1'b1);
    wait_edge(k + 1 + D);
    irq_mask = 8'h00;
    push(cyc + 1, 8'h01, 8'h04, 1'b0);
    @(negedge clk);
    irq_mask = 8'h04; clr_valid = 1'b1; clr_mask = 8'h04;
    push(cyc + 1, 8'h01, 8'h00, 1'b0);
    @(negedge clk);
    clr_valid = 1'b0; clr_mask = '0;

    // set and clear on the same edge: set wins
    pin = 8'h05;
    k = cyc + 1;
    push(k + 1 + D, 8'h05, 8'h00, 1'b0);
    wait_edge(k + 2 + D);
    pin = 8'h01;
    k = cyc + 1;
    wait_edge(k + D);
    clr_valid = 1'b1; clr_mask = 8'h04;
    push(k + 1 + D, 8'h01, 8'h04, 1'b1);
    @(negedge clk);
    clr_valid = 1'b0; clr_mask = '0;
    push(cyc + 1, 8'h01, 8'h04, 1'b1);
    @(negedge clk);

    // fill pending with 0xFF
    fall_en = 8'h01; rise_en = 8'h00; pin = 8'h00;
    k = cyc + 1;
    push(k + 1 + D, 8'h00, 8'h05, 1'b1);
    wait_edge(k + 2 + D);
    rise_en = 8'hFF; fall_en = 8'h00; irq_mask = 8'hFF; pin = 8'hFF;
    k = cyc + 1;
    push(k + 1 + D, 8'hFF, 8'hFF, 1'b1);
    wait_edge(k + 2 + D);

    // asynchronous reset with counters at 2
    pin = 8'h00;
    k = cyc + 1;
    wait_edge(k + 3);
    rst_n = 1'b0;
    #1;
    cmp("async_reset", {st_o, pd_o, irq_o}, {8'h00, 8'h00, 1'b0});
    pin = 8'h80; rise_en = 8'h80; fall_en = 8'h00;
    push(cyc + 1, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = cyc + 1;
    push(k + D, 8'h00, 8'h00, 1'b0);
    push(k + 1 + D, 8'h80, 8'h80, 1'b1);
    wait_edge(k + 3 + D);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input-conditioning stage directly upstream of the GPIO register block: takes raw asynchronous input pins, synchronises them, optionally debounces them, and detects rising/falling edges into sticky pending bits with a combined interrupt line. Its `stable_out` and `pending` outputs are the values the CPU-side GPIO registers capture and read back. Clear requests arrive from the same memory-mapped write path that drives the GPIO registers.

## Interface
- `WIDTH`, 32, number of input pins handled (≥1)
- `DEBOUNCE_CYCLES`, 16, consecutive cycles a new level must persist before acceptance (≥1); counter width is `$clog2(DEBOUNCE_CYCLES+1)`
- `clk`  in  1  system clock; one clock, all state on posedge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pin_in`  in  WIDTH  raw external pins, asynchronous to `clk`
- `rise_en`  in  WIDTH  per-bit enable: rising edge of `stable_out` sets pending
- `fall_en`  in  WIDTH  per-bit enable: falling edge of `stable_out` sets pending
- `irq_mask`  in  WIDTH  per-bit enable of pending bits onto `irq`
- `clr_valid`  in  1  one-cycle strobe: apply `clr_mask`
- `clr_mask`  in  WIDTH  write-1-to-clear mask for `pending`
- `stable_out`  out  WIDTH  synchronised and debounced pin levels (registered)
- `pending`  out  WIDTH  sticky edge-pending bits (registered)
- `irq`  out  1  `|(pending & irq_mask)`, combinational from registers and `irq_mask`

## Operation
- Per-bit 2-flop synchroniser: `sync1 <= pin_in`, `sync2 <= sync1`.
- Debounce, per bit: if `sync2 == stable_out`, counter is cleared to 0. Otherwise, if counter == `DEBOUNCE_CYCLES-1`, `stable_out` takes `sync2` and counter clears; else counter increments. A glitch shorter than `DEBOUNCE_CYCLES` cycles on `sync2` never reaches `stable_out`, and the count restarts from 0 on every return to the stable level.
- Edge detect, per bit, evaluated on the next-state value: the rise event is stable going 0→1 with `rise_en`; the fall event is 1→0 with `fall_en`. An event sets `pending` on the same edge that `stable_out` changes.
- Clear: when `clr_valid=1`, bits where `clr_mask=1` are cleared. If set and clear hit the same bit on the same edge, set wins and the bit stays 1.
- Changing `rise_en`/`fall_en` does not alter existing pending bits. `irq_mask` gates only `irq`.
- Reset (any time, including mid-count): `sync1`, `sync2`, `stable_out`, all counters, and `pending` go to 0. `irq` therefore reads 0.
- After reset release, pins held high are treated as a 0→1 transition and produce a rising event once debounced, if enabled.

## Timing
- Pin change settled before posedge k: `sync2` reflects it after posedge k+1; `stable_out` changes at posedge k+1+`DEBOUNCE_CYCLES`; `pending` is set on that same edge; `irq` follows combinationally.
- Clear latency: `pending` bit reads 0 one edge after `clr_valid`.
- No backpressure; `clr_valid` is a single-cycle strobe sampled on each posedge. Holding it high simply reapplies the clear.
- All bits are independent; any combination of bits may change, set, or clear on the same edge.

## Configuration
- `GPIO_DEBOUNCE_EN` defined: debounce counters are present as described above.
- Not defined: counters are removed; `stable_out <= sync2` every cycle, so latency is posedge k+2, which is identical to `DEBOUNCE_CYCLES=1`. `DEBOUNCE_CYCLES` is ignored.
- Edge detection, pending, and `irq` behave the same in both builds.

## Test plan
- WIDTH=8, N=4, `GPIO_DEBOUNCE_EN`: reset with `pin_in=0x00`, then all outputs are 0. Set `pin_in=0x01`, `rise_en=0x01`, `irq_mask=0x01` before edge k → `stable_out=0x01` and `pending=0x01` at edge k+5, `irq=1`.
- Glitch: `pin_in[1]` high for 3 cycles, then low → `stable_out[1]` stays 0 and `pending[1]` stays 0. A 4-cycle pulse instead → `stable_out[1]` goes 1, then returns to 0 after release.
- Fall edge with `fall_en=0x04`, `rise_en=0`: bit 2 rises → no pending. Bit 2 falls → `pending=0x04`. Then `clr_valid=1`, `clr_mask=0x04` → `pending=0x00` next edge and `irq=0`.
- Simultaneous: a fall event on bit 2 coincides with `clr_valid=1`, `clr_mask=0x04` → `pending[2]=1` after the edge.
- Assert `rst_n=0` asynchronously mid-debounce (counter=2) with `pending=0xFF` → all outputs are 0 immediately. Release with `pin_in=0x80`, `rise_en=0x80` → `pending=0x80` at release+5 edges.
- Build without `GPIO_DEBOUNCE_EN`: `pin_in=0x10` before edge k → `stable_out=0x10` at edge k+2. A 1-cycle glitch on bit 5 appears on `stable_out[5]` for one cycle.
